// File: rtl/horner_q16_pkg.sv
// Shared Q16.16 constants and FSM state type for the Horner datapath
// (multiplier, divider, sequencer).
package horner_q16_pkg;

    localparam int unsigned Q16_FRAC  = 16;
    localparam int unsigned Q16_W     = 32;
    localparam int unsigned DIV_NITER = Q16_W + Q16_FRAC + 1;

    localparam logic [Q16_W-1:0] Q16_ONE = 32'h0001_0000;
    localparam logic [Q16_W-1:0] Q16_MAX = 32'h7FFF_FFFF;
    localparam logic [Q16_W-1:0] Q16_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ROUND,
        DONE
    } q16_state_e;

endpackage

// File: rtl/q16_round_sat.sv
// Combinational round-half-away-from-zero, sign restore and saturation of an
// unsigned quotient carrying one guard bit.
module q16_round_sat
    import horner_q16_pkg::*;
#(
    parameter int unsigned W     = Q16_W,
    parameter int unsigned NITER = DIV_NITER
) (
    input  logic [NITER-1:0] q_i,
    input  logic             sign_i,
    input  logic             dbz_i,
    input  logic             a_sign_i,
    output logic [W-1:0]     y_o,
    output logic             overflow_o,
    output logic             div_by_zero_o
);

    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};

    logic [NITER-1:0] mag;
    logic [W-1:0]     mag_lo;
    logic             pos_ovf;
    logic             neg_ovf;

    // (q + 1) >> 1 without needing an extra carry bit
    always_comb begin
        mag     = (q_i >> 1) + NITER'(q_i[0]);
        mag_lo  = mag[W-1:0];
        pos_ovf = |mag[NITER-1:W-1];
        neg_ovf = (|mag[NITER-1:W]) || (mag[W-1] && (|mag[W-2:0]));
    end

    always_comb begin
        y_o           = sign_i ? (-mag_lo) : mag_lo;
        overflow_o    = 1'b0;
        div_by_zero_o = 1'b0;
        if (dbz_i) begin
            div_by_zero_o = 1'b1;
            y_o           = a_sign_i ? NEG_MAX : POS_MAX;
        end else if (sign_i && neg_ovf) begin
            overflow_o = 1'b1;
            y_o        = NEG_MAX;
        end else if (!sign_i && pos_ovf) begin
            overflow_o = 1'b1;
            y_o        = POS_MAX;
        end
    end

endmodule

// File: rtl/div_q16.sv
// Sequential signed Q16.16 divider, y = round(a * 2^16 / b), radix-2
// restoring, one quotient bit per clock, valid/ready on both sides.
module div_q16
    import horner_q16_pkg::*;
#(
    parameter int unsigned W    = Q16_W,
    parameter int unsigned FRAC = Q16_FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int unsigned NITER = W + FRAC + 1;
    localparam int unsigned CNT_W = $clog2(NITER);

    q16_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NITER-1:0] dq_q, dq_d;       // dividend bits out at MSB, quotient bits in at LSB
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     bmag_q, bmag_d;
    logic             sign_q, sign_d;
    logic             dbz_q, dbz_d;
    logic             asign_q, asign_d;
    logic [W-1:0]     y_q, y_d;
    logic             ovf_q, ovf_d;
    logic             dbzf_q, dbzf_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;

    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [W:0]       rem_sh;
    logic             rem_ge;
    logic [W-1:0]     rem_diff;
    logic [W-1:0]     rs_y;
    logic             rs_ovf;
    logic             rs_dbz;

    always_comb begin
        a_mag    = a[W-1] ? (-a) : a;
        b_mag    = b[W-1] ? (-b) : b;
        rem_sh   = {rem_q, dq_q[NITER-1]};
        rem_ge   = rem_sh >= {1'b0, bmag_q};
        rem_diff = W'(rem_sh - {1'b0, bmag_q});
    end

    q16_round_sat #(
        .W     (W),
        .NITER (NITER)
    ) u_round_sat (
        .q_i           (dq_q),
        .sign_i        (sign_q),
        .dbz_i         (dbz_q),
        .a_sign_i      (asign_q),
        .y_o           (rs_y),
        .overflow_o    (rs_ovf),
        .div_by_zero_o (rs_dbz)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        bmag_d      = bmag_q;
        sign_d      = sign_q;
        dbz_d       = dbz_q;
        asign_d     = asign_q;
        y_d         = y_q;
        ovf_d       = ovf_q;
        dbzf_d      = dbzf_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = a[W-1] ^ b[W-1];
                    asign_d = a[W-1];
                    bmag_d  = b_mag;
                    dq_d    = {a_mag, {(FRAC+1){1'b0}}};
                    rem_d   = '0;
                    cnt_d   = CNT_W'(NITER - 1);
                    dbz_d   = (b == '0);
                    state_d = CALC;
                end
            end
            CALC: begin
                dq_d  = {dq_q[NITER-2:0], rem_ge};
                rem_d = rem_ge ? rem_diff : rem_sh[W-1:0];
                if (cnt_q == '0) begin
                    state_d = ROUND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ROUND: begin
                y_d         = rs_y;
                ovf_d       = rs_ovf;
                dbzf_d      = rs_dbz;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            bmag_q      <= '0;
            sign_q      <= 1'b0;
            dbz_q       <= 1'b0;
            asign_q     <= 1'b0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            dbzf_q      <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            bmag_q      <= bmag_d;
            sign_q      <= sign_d;
            dbz_q       <= dbz_d;
            asign_q     <= asign_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            dbzf_q      <= dbzf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign y           = y_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbzf_q;

endmodule

// File: tb/tb_div_q16.sv
// Self-checking bench for div_q16: directed vector table, random operands
// against an exact rational-rounding model, backpressure and mid-run reset.
module tb_div_q16;
    import horner_q16_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        div_by_zero;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_q16 dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .y           (y),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        ovf;
        logic        dbz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Exact rounding: floor(|a|*2^16/|b| + 1/2), then sign and clamp
    function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                  output logic [31:0] my, output logic mo, output logic md);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned mag;
        logic            neg;
        mo = 1'b0;
        md = 1'b0;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (mb == 32'h0) begin
            md = 1'b1;
            my = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            return;
        end
        ua  = (sa < 0) ? -sa : sa;
        ub  = (sb < 0) ? -sb : sb;
        mag = (ua * 64'd131072 + ub) / (64'd2 * ub);
        neg = ma[31] ^ mb[31];
        if (!neg && mag > 64'h7FFF_FFFF) begin
            my = 32'h7FFF_FFFF;
            mo = 1'b1;
        end else if (neg && mag > 64'h8000_0000) begin
            my = 32'h8000_0000;
            mo = 1'b1;
        end else begin
            my = neg ? 32'(-mag) : 32'(mag);
        end
    endfunction

    task automatic start_div(input logic [31:0] va, input logic [31:0] vb);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
    endtask

    task automatic accept_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("in_ready_after_hs", 64'(in_ready), 64'd1);
    endtask

    task automatic full_div(input string tag, input logic [31:0] va, input logic [31:0] vb,
                            input logic [31:0] ey, input logic eo, input logic ed);
        int lat;
        start_div(va, vb);
        wait_valid(lat);
        check({tag, "_latency"}, 64'(lat), 64'd50);
        check({tag, "_y"}, 64'(y), 64'(ey));
        check({tag, "_overflow"}, 64'(overflow), 64'(eo));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
        check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
        accept_result();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] ey;
        logic        eo;
        logic        ed;
        int          lat;

        vecs.push_back('{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, 1'b0});
        vecs.push_back('{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0001, 32'h0002_0000, 32'h0000_0001, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0002_0000, 32'hFFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFB_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h0000_0000, 32'hFFFE_0000, 32'h0000_0000, 1'b0, 1'b0});

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_y", 64'(y), 64'd0);
        check("reset_flags", 64'({overflow, div_by_zero}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            full_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].ovf, vecs[i].dbz);
        end

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (i % 8 == 7) rb = '0;
            model(ra, rb, ey, eo, ed);
            full_div($sformatf("rnd%0d", i), ra, rb, ey, eo, ed);
        end

        // Backpressure: result and flags hold, new requests ignored
        model(32'h0005_0000, 32'h0002_0000, ey, eo, ed);
        start_div(32'h0005_0000, 32'h0002_0000);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'd50);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 32'h0000_1234;
            b        = 32'h0000_0001;
            @(posedge clk);
            #1;
            check("bp_y_hold", 64'(y), 64'(ey));
            check("bp_out_valid_hold", 64'(out_valid), 64'd1);
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        accept_result();
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_phantom_result", 64'(out_valid), 64'd0);

        // Reset while CALC is in progress
        start_div(32'h0003_0000, 32'h0002_0000);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_y", 64'(y), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid_after", 64'(out_valid), 64'd0);
        check("midrst_y_after", 64'(y), 64'd0);

        full_div("post_reset_6div3", 32'h0006_0000, 32'h0003_0000, 32'h0002_0000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
